// File: rtl/hammer_pkg.sv
// Shared types and constants for the hammer sprite read engine:
// swing state encoding, colour-key default and the 16-entry RGB palette.
package hammer_pkg;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } swing_state_t;

  localparam int KEY_COLOR_DEF = 0;

  localparam logic [11:0] PALETTE [16] = '{
    12'h000, 12'hFFF, 12'hAAA, 12'h555,
    12'h852, 12'h642, 12'h431, 12'hCCC,
    12'h888, 12'hFE0, 12'hF80, 12'hC00,
    12'h0F0, 12'h00F, 12'h0FF, 12'hF0F
  };

  function automatic logic [11:0] palette_rgb(input logic [3:0] idx);
    return PALETTE[idx];
  endfunction

endpackage

// File: rtl/hammer_swing_fsm.sv
// Two-frame swing animation: a strike latches until the next frame_tick, then the
// DOWN image is held for SWING_FRAMES frames before returning to UP.
module hammer_swing_fsm
  import hammer_pkg::*;
#(
  parameter int SWING_FRAMES = 6
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_tick,
  input  logic strike,
  output logic swing_active,
  output logic hit
);

  localparam int CNT_W = $clog2(SWING_FRAMES + 1);

  swing_state_t     state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             pend_q;

  // Swing state, frame counter, pending strike and hit pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= UP;
      cnt_q   <= {CNT_W{1'b0}};
      pend_q  <= 1'b0;
      hit     <= 1'b0;
    end else begin
      hit <= 1'b0;
      case (state_q)
        UP: begin
          if (frame_tick && (pend_q || strike)) begin
            state_q <= DOWN;
            cnt_q   <= CNT_W'(SWING_FRAMES - 1);
            pend_q  <= 1'b0;
            hit     <= 1'b1;
          end else if (strike) begin
            pend_q <= 1'b1;
          end else begin
            pend_q <= pend_q;
          end
        end
        DOWN: begin
          // Strikes during a swing are dropped, never queued for a re-swing.
          pend_q <= 1'b0;
          if (frame_tick) begin
            if (cnt_q == {CNT_W{1'b0}}) begin
              state_q <= UP;
            end else begin
              cnt_q <= cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end else begin
            cnt_q <= cnt_q;
          end
        end
        default: begin
          state_q <= UP;
          cnt_q   <= {CNT_W{1'b0}};
          pend_q  <= 1'b0;
        end
      endcase
    end
  end

  assign swing_active = (state_q == DOWN);

endmodule

// File: rtl/hammer_sprite_reader.sv
// Read-side engine for the hammer bitmap RAM: scan coordinates to RAM address,
// region flag aligned with the RAM's registered output, palette lookup with colour key.
module hammer_sprite_reader
  import hammer_pkg::*;
#(
  parameter int COORD_W      = 11,
  parameter int SPRITE_W     = 32,
  parameter int SPRITE_H     = 32,
  parameter int DATA_WIDTH   = 4,
  parameter int ADDR_WIDTH   = 11,
  parameter int SWING_FRAMES = 6,
  parameter int KEY_COLOR    = KEY_COLOR_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [COORD_W-1:0]    x,
  input  logic [COORD_W-1:0]    y,
  input  logic [COORD_W-1:0]    x0,
  input  logic [COORD_W-1:0]    y0,
  input  logic                  frame_tick,
  input  logic                  strike,
  output logic [ADDR_WIDTH-1:0] ram_addr_r,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  output logic [11:0]           sprite_rgb,
  output logic                  sprite_on,
  output logic                  swing_active,
  output logic                  hit
);

  localparam int LW = $clog2(SPRITE_W);
  localparam int LH = $clog2(SPRITE_H);

  logic [COORD_W-1:0]    x0_q, x0_d, y0_q, y0_d;
  logic [COORD_W-1:0]    dx, dy;
  logic                  in_reg;
  logic                  in1_q, in2_q;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic                  on_d;
  logic [11:0]           rgb_d;

  hammer_swing_fsm #(
    .SWING_FRAMES(SWING_FRAMES)
  ) u_swing (
    .clk         (clk),
    .reset       (reset),
    .frame_tick  (frame_tick),
    .strike      (strike),
    .swing_active(swing_active),
    .hit         (hit)
  );

  // Region test, address formation and pixel colour for the three pipeline stages
  always_comb begin
    dx     = x - x0_q;
    dy     = y - y0_q;
    // The x>=x0 / y>=y0 terms stop a wrapped dx/dy from re-entering the sprite.
    in_reg = (x >= x0_q) && (dx < COORD_W'(SPRITE_W)) &&
             (y >= y0_q) && (dy < COORD_W'(SPRITE_H));
    addr_d = {swing_active, dy[LH-1:0], dx[LW-1:0]};
    on_d   = in2_q && (ram_dout != DATA_WIDTH'(KEY_COLOR));
    if (on_d) begin
      rgb_d = palette_rgb(4'(ram_dout));
    end else begin
      rgb_d = 12'h000;
    end
    if (frame_tick) begin
      x0_d = x0;
      y0_d = y0;
    end else begin
      x0_d = x0_q;
      y0_d = y0_q;
    end
  end

  // Origin registers and pipeline stages
  always_ff @(posedge clk) begin
    if (reset) begin
      x0_q       <= {COORD_W{1'b0}};
      y0_q       <= {COORD_W{1'b0}};
      ram_addr_r <= {ADDR_WIDTH{1'b0}};
      in1_q      <= 1'b0;
      in2_q      <= 1'b0;
      sprite_on  <= 1'b0;
      sprite_rgb <= 12'h000;
    end else begin
      x0_q       <= x0_d;
      y0_q       <= y0_d;
      ram_addr_r <= addr_d;
      in1_q      <= in_reg;
      in2_q      <= in1_q;
      sprite_on  <= on_d;
      sprite_rgb <= rgb_d;
    end
  end

endmodule

// File: tb/tb_hammer_sprite_reader.sv
// Directed bench for hammer_sprite_reader with a behavioural 1-cycle-latency bitmap RAM.
module tb_hammer_sprite_reader;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] x, y, x0, y0;
  logic        frame_tick, strike;
  logic [10:0] ram_addr_r;
  logic [3:0]  ram_dout;
  logic [11:0] sprite_rgb;
  logic        sprite_on, swing_active, hit;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hammer_sprite_reader dut (
    .clk         (clk),
    .reset       (reset),
    .x           (x),
    .y           (y),
    .x0          (x0),
    .y0          (y0),
    .frame_tick  (frame_tick),
    .strike      (strike),
    .ram_addr_r  (ram_addr_r),
    .ram_dout    (ram_dout),
    .sprite_rgb  (sprite_rgb),
    .sprite_on   (sprite_on),
    .swing_active(swing_active),
    .hit         (hit)
  );

  // Bitmap RAM: frame 0 holds addr[3:0]^5, frame 1 holds addr[3:0]^9.
  always @(posedge clk) begin
    if (ram_addr_r[10]) ram_dout <= ram_addr_r[3:0] ^ 4'h9;
    else                ram_dout <= ram_addr_r[3:0] ^ 4'h5;
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick(input logic s);
    frame_tick = 1'b1;
    strike     = s;
    cyc(1);
    frame_tick = 1'b0;
    strike     = 1'b0;
  endtask

  task automatic pixel(input string tag, input logic [10:0] xi, input logic [10:0] yi,
                       input logic [10:0] e_addr, input logic e_on, input logic [11:0] e_rgb);
    x = xi;
    y = yi;
    cyc(1);
    check_val({tag, "_addr"}, 32'(ram_addr_r), 32'(e_addr));
    cyc(2);
    check_val({tag, "_on"}, 32'(sprite_on), 32'(e_on));
    check_val({tag, "_rgb"}, 32'(sprite_rgb), 32'(e_rgb));
  endtask

  initial begin
    reset = 1'b1; x = 11'd0; y = 11'd0; x0 = 11'd0; y0 = 11'd0;
    frame_tick = 1'b0; strike = 1'b0;
    cyc(3);
    check_val("rst_on", 32'(sprite_on), 32'd0);
    check_val("rst_rgb", 32'(sprite_rgb), 32'd0);
    check_val("rst_addr", 32'(ram_addr_r), 32'd0);
    check_val("rst_swing", 32'(swing_active), 32'd0);
    check_val("rst_hit", 32'(hit), 32'd0);
    reset = 1'b0;

    // Origin load and basic region / colour-key cases
    x0 = 11'd100; y0 = 11'd50;
    tick(1'b0);
    check_val("tick_nostrike_swing", 32'(swing_active), 32'd0);
    pixel("p_origin", 11'd100, 11'd50, 11'd0,   1'b1, 12'h642);
    pixel("p_right",  11'd131, 11'd50, 11'd31,  1'b1, 12'hF80);
    pixel("p_rout",   11'd132, 11'd50, 11'd0,   1'b0, 12'h000);
    pixel("p_lout",   11'd99,  11'd50, 11'd31,  1'b0, 12'h000);
    pixel("p_key",    11'd105, 11'd50, 11'd5,   1'b0, 12'h000);
    pixel("p_bottom", 11'd100, 11'd81, 11'd992, 1'b1, 12'h642);
    pixel("p_bout",   11'd100, 11'd82, 11'd0,   1'b0, 12'h000);

    // Mid-frame strike waits for frame_tick, then a six-frame swing
    strike = 1'b1;
    cyc(1);
    strike = 1'b0;
    cyc(3);
    check_val("pend_swing", 32'(swing_active), 32'd0);
    check_val("pend_hit", 32'(hit), 32'd0);
    tick(1'b0);
    check_val("swing_hit", 32'(hit), 32'd1);
    check_val("swing_active", 32'(swing_active), 32'd1);
    cyc(1);
    check_val("swing_hit_end", 32'(hit), 32'd0);
    pixel("p_down", 11'd100, 11'd50, 11'h400, 1'b1, 12'hFE0);
    for (int i = 1; i <= 5; i++) begin
      tick(1'b0);
      check_val("swing_hold", 32'(swing_active), 32'd1);
    end
    tick(1'b0);
    check_val("swing_done", 32'(swing_active), 32'd0);

    // Strike coincident with frame_tick, then an ignored strike during DOWN
    tick(1'b1);
    check_val("coinc_hit", 32'(hit), 32'd1);
    check_val("coinc_swing", 32'(swing_active), 32'd1);
    cyc(2);
    strike = 1'b1;
    cyc(1);
    strike = 1'b0;
    cyc(2);
    check_val("down_strike_hit", 32'(hit), 32'd0);
    for (int i = 1; i <= 5; i++) begin
      tick(1'b0);
      check_val("coinc_hold", 32'(swing_active), 32'd1);
    end
    tick(1'b0);
    check_val("coinc_done", 32'(swing_active), 32'd0);
    tick(1'b0);
    check_val("no_reswing", 32'(swing_active), 32'd0);
    check_val("no_reswing_hit", 32'(hit), 32'd0);

    // Reset during DOWN wins over a simultaneous tick and strike
    tick(1'b1);
    check_val("pre_rst_swing", 32'(swing_active), 32'd1);
    cyc(2);
    reset = 1'b1; frame_tick = 1'b1; strike = 1'b1;
    cyc(1);
    reset = 1'b0; frame_tick = 1'b0; strike = 1'b0;
    check_val("midrst_swing", 32'(swing_active), 32'd0);
    check_val("midrst_hit", 32'(hit), 32'd0);
    check_val("midrst_on", 32'(sprite_on), 32'd0);

    // Origin changes take effect only at frame_tick
    x0 = 11'd100; y0 = 11'd50;
    tick(1'b0);
    x0 = 11'd300;
    pixel("p_oldorg", 11'd100, 11'd50, 11'd0,  1'b1, 12'h642);
    tick(1'b0);
    pixel("p_neworg_old", 11'd100, 11'd50, 11'd24, 1'b0, 12'h000);
    pixel("p_neworg",     11'd300, 11'd50, 11'd0,  1'b1, 12'h642);

    // Right-edge origin clips without wrapping to x=0
    x0 = 11'd2030;
    tick(1'b0);
    pixel("p_edge", 11'd2047, 11'd50, 11'd17, 1'b1, 12'h852);
    pixel("p_wrap", 11'd0,    11'd50, 11'd18, 1'b0, 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
